// File: rtl/shift_pkg.sv
// Shared types and saturation limits for the shift/accumulate datapath.
// Latency: none (package only).
// Backpressure: not applicable.
package shift_pkg;

  // Defaults match the arithmetic_shift output width and a modest accumulator.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 12;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Largest value a signed w-bit number can hold.
  function automatic int max_s(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value a signed w-bit number can hold.
  function automatic int min_s(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/shift_accum_sat_add.sv
// Saturating signed add of a DATA_W sample into an ACC_W accumulator value.
// Latency: combinational.
// Backpressure: not applicable; pure function of its inputs.
module sat_add
  import shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     clamp
);

  // One extra bit of headroom so the true sum of two in-range operands is exact.
  localparam logic signed [ACC_W:0] WIDE_MAX = (ACC_W + 1)'(max_s(ACC_W));
  localparam logic signed [ACC_W:0] WIDE_MIN = (ACC_W + 1)'(min_s(ACC_W));

  logic signed [ACC_W:0] a_ext;
  logic signed [ACC_W:0] b_ext;
  logic signed [ACC_W:0] wide;

  assign a_ext = {a[ACC_W-1], a};
  assign b_ext = {{(ACC_W + 1 - DATA_W){b[DATA_W-1]}}, b};
  assign wide  = a_ext + b_ext;

  // Clamp the exact sum back into ACC_W signed range and flag when that happened.
  always_comb begin
    sum   = wide[ACC_W-1:0];
    clamp = 1'b0;
    if (wide > WIDE_MAX) begin
      sum   = WIDE_MAX[ACC_W-1:0];
      clamp = 1'b1;
    end else if (wide < WIDE_MIN) begin
      sum   = WIDE_MIN[ACC_W-1:0];
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/shift_accum.sv
// Sums BLOCK_LEN signed samples into a saturating accumulator and presents the block sum.
// Latency: out_valid rises the cycle after the last sample; BLOCK_LEN+1 cycles per block.
// Backpressure: in_ready drops while a sum is held; sum/sat held stable until out_ready.
module shift_accum
  import shift_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int BLOCK_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_sat
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     sat, sat_nxt;
  logic signed [ACC_W-1:0]  add_sum;
  logic                     add_clamp;

  sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .a     (acc),
    .b     (in_data),
    .sum   (add_sum),
    .clamp (add_clamp)
  );

  // Handshake outputs come from state only, so nothing combinational crosses in->out.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_sum   = out_valid ? acc : '0;
  assign out_sat   = out_valid & sat;

  // Next-state and datapath updates; clear overrides whatever the FSM would do.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    case (state)
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = add_sum;
          sat_nxt = sat | add_clamp;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // Samples offered here are ignored; they are taken once back in ACCUM.
        if (out_ready) begin
          acc_nxt   = '0;
          sat_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
    endcase
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      sat_nxt   = 1'b0;
    end
  end

  // State, accumulator, counter and sticky saturation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_shift_accum.sv
// Directed bench for shift_accum: ACC_W=12 and ACC_W=9 instances share one stimulus.
// Latency: inputs change and outputs are sampled 1ns after each rising edge.
// Backpressure: out_ready is driven explicitly per scenario.
module tb_shift_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              out_ready;

  logic              rdy12, vld12, sat12;
  logic signed [11:0] sum12;
  logic              rdy9, vld9, sat9;
  logic signed [8:0] sum9;

  int checks = 0;
  int errors = 0;

  shift_accum #(.DATA_W(8), .ACC_W(12), .BLOCK_LEN(4), .CNT_W(4)) dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (rdy12),
    .in_data   (in_data),
    .out_valid (vld12),
    .out_ready (out_ready),
    .out_sum   (sum12),
    .out_sat   (sat12)
  );

  shift_accum #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(4), .CNT_W(4)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (rdy9),
    .in_data   (in_data),
    .out_valid (vld9),
    .out_ready (out_ready),
    .out_sum   (sum9),
    .out_sat   (sat9)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 8'(v);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_vld", vld12, 0);
    chk("rst_rdy", rdy12, 1);
    chk("rst_sum", sum12, 0);
    chk("rst_sat", sat12, 0);
    #1 rst_n = 1'b1;
    step();
    chk("rel_rdy", rdy12, 1);

    // Nominal block
    send(8); send(-8); send(-1);
    chk("nom_vld_early", vld12, 0);
    send(31);
    chk("nom_vld", vld12, 1);
    chk("nom_rdy", rdy12, 0);
    chk("nom_sum", sum12, 30);
    chk("nom_sat", sat12, 0);
    chk("nom_sum9", sum9, 30);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("nom_drain_vld", vld12, 0);
    chk("nom_drain_rdy", rdy12, 1);

    // Positive saturation on the narrow accumulator only
    send(127); send(127); send(127); send(0);
    chk("satp_sum9", sum9, 255);
    chk("satp_sat9", sat9, 1);
    chk("satp_sum12", sum12, 381);
    chk("satp_sat12", sat12, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Negative saturation
    send(-128); send(-128); send(-128); send(-128);
    chk("satn_sum9", sum9, -256);
    chk("satn_sat9", sat9, 1);
    chk("satn_sum12", sum12, -512);
    chk("satn_sat12", sat12, 0);

    // Backpressure: held output, input toggling is ignored
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'sd50;
      step();
      chk("bp_vld", vld12, 1);
      chk("bp_rdy", rdy12, 0);
      chk("bp_sum", sum12, -512);
      chk("bp_sat9", sat9, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_sat_cleared", sat9, 0);
    send(3); send(3); send(3);
    chk("bp_cnt_vld", vld12, 0);
    send(3);
    chk("bp_next_vld", vld12, 1);
    chk("bp_next_sum", sum12, 12);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Clear mid-block drops partial sum and the sample offered with it
    send(5); send(5);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'sd9;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    send(1); send(1); send(1);
    chk("clr_vld_early", vld12, 0);
    send(1);
    chk("clr_vld", vld12, 1);
    chk("clr_sum", sum12, 4);
    chk("clr_sat", sat12, 0);

    // Clear while holding drops the pending output
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clrh_vld", vld12, 0);
    chk("clrh_rdy", rdy12, 1);

    // Drain and refill in the same HOLD cycle: offered sample waits a cycle
    send(8); send(8); send(8); send(8);
    chk("hs_hold_sum", sum12, 32);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'sd7;
    step();
    out_ready = 1'b0;
    chk("hs_vld", vld12, 0);
    step();
    in_valid = 1'b0;
    send(1); send(1);
    chk("hs_vld_early", vld12, 0);
    send(1);
    chk("hs_vld_late", vld12, 1);
    chk("hs_sum", sum12, 10);

    // Asynchronous reset while holding
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", vld12, 0);
    chk("arst_sum", sum12, 0);
    chk("arst_rdy", rdy12, 1);
    #2 rst_n = 1'b1;
    step();
    send(2); send(2); send(2); send(2);
    chk("arst_post_vld", vld12, 1);
    chk("arst_post_sum", sum12, 8);
    chk("arst_post_sat", sat12, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
